// File: rtl/sevseg_scroll_decoder.sv
// Receive-side checker for the six-digit "GO BUFFS" scrolling display: decodes glyphs,
// locks onto the scroll phase, flags sequence errors. Optional: SCROLL_STALL_TOLERANT_EN.
module sevseg_scroll_decoder #(
    parameter int LOCK_FRAMES = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 seg_valid,
    input  logic [6:0]           hex0,
    input  logic [6:0]           hex1,
    input  logic [6:0]           hex2,
    input  logic [6:0]           hex3,
    input  logic [6:0]           hex4,
    input  logic [6:0]           hex5,
    output logic [23:0]          char_out,
    output logic [3:0]           phase,
    output logic                 locked,
    output logic                 err,
    output logic                 illegal,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

    state_t     state;
    logic [3:0] cnt;
    logic [6:0] seg   [6];
    logic [3:0] glyph [6];
    logic [23:0] char_next;
    logic       any_bad;
    logic       win_ok;
    logic       hit;
    logic [3:0] hit_phase;
    logic [3:0] next_phase;
    logic       adv;
    logic       rep;

    function automatic logic [3:0] decode(input logic [6:0] s);
        case (s)
            7'b1000010: return 4'd0;
            7'b1000000: return 4'd1;
            7'b1111111: return 4'd2;
            7'b0000011: return 4'd3;
            7'b0010011: return 4'd4;
            7'b0001110: return 4'd5;
            7'b0010010: return 4'd7;
            default:    return 4'hF;
        endcase
    endfunction

    function automatic logic [3:0] msg_glyph(input int unsigned pos);
        case (pos)
            0:       return 4'd0;
            1:       return 4'd1;
            3:       return 4'd3;
            4:       return 4'd4;
            5, 6:    return 4'd5;
            7:       return 4'd7;
            default: return 4'd2;
        endcase
    endfunction

    // Windows are distinct, so at most one phase can set hit.
    always_comb begin
        seg[0] = hex0;
        seg[1] = hex1;
        seg[2] = hex2;
        seg[3] = hex3;
        seg[4] = hex4;
        seg[5] = hex5;
        any_bad   = 1'b0;
        char_next = '0;
        for (int unsigned k = 0; k < 6; k++) begin
            glyph[k] = decode(seg[k]);
            if (glyph[k] == 4'hF) any_bad = 1'b1;
        end
        char_next = {glyph[0], glyph[1], glyph[2], glyph[3], glyph[4], glyph[5]};
        hit       = 1'b0;
        hit_phase = '0;
        win_ok    = 1'b0;
        for (int unsigned p = 0; p < 10; p++) begin
            win_ok = 1'b1;
            for (int unsigned k = 0; k < 6; k++) begin
                if (glyph[k] != msg_glyph((p + k) % 10)) win_ok = 1'b0;
            end
            if (win_ok) begin
                hit       = 1'b1;
                hit_phase = 4'(p);
            end
        end
        next_phase = (phase == 4'd9) ? 4'd0 : phase + 4'd1;
        adv        = hit && (hit_phase == next_phase);
        rep        = hit && (hit_phase == phase);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HUNT;
            cnt      <= '0;
            phase    <= '0;
            locked   <= 1'b0;
            err      <= 1'b0;
            illegal  <= 1'b0;
            err_cnt  <= '0;
            char_out <= '1;
        end else begin
            err <= 1'b0;
            if (seg_valid) begin
                char_out <= char_next;
                illegal  <= any_bad;
                case (state)
                    HUNT: begin
                        if (hit) begin
                            phase <= hit_phase;
                            cnt   <= 4'd1;
                            if (LOCK_N == 4'd1) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end else begin
                                state <= CONFIRM;
                            end
                        end
                    end
                    CONFIRM: begin
                        if (adv) begin
                            phase <= next_phase;
                            cnt   <= cnt + 4'd1;
                            if (cnt + 4'd1 == LOCK_N) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
`ifdef SCROLL_STALL_TOLERANT_EN
                        end else if (!rep) begin
`else
                        end else begin
`endif
                            state <= HUNT;
                        end
                    end
                    LOCKED: begin
                        if (adv) begin
                            phase <= next_phase;
`ifdef SCROLL_STALL_TOLERANT_EN
                        end else if (!rep) begin
`else
                        end else begin
`endif
                            state  <= HUNT;
                            locked <= 1'b0;
                            err    <= 1'b1;
                            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
